// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the memory arbiter that sits between the CPU control path,
// the program loader/debug port and the single synchronous-read byte memory.
//   arb_state_t : IDLE (arbitrate/issue) or READ_WAIT (read latency running)
//   arb_owner_t : which requester owns the read currently in flight
// -----------------------------------------------------------------------------
package mem_arb_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      READ_WAIT = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_LDR  = 2'd2
   } arb_owner_t;

endpackage : mem_arb_pkg

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one synchronous-read memory between the CPU and the loader port.
// One access is in flight at a time. The CPU has fixed priority, but after
// STARVE_MAX consecutive contested CPU grants the loader is forced through.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata: CPU request, held until cpu_gnt
//   cpu_gnt             : same-cycle accept pulse
//   cpu_rvalid/rdata    : read completion pulse and held read data
//   ldr_*               : loader port, same rules as the CPU port
//   mem_en/we/addr/wdata: memory strobes, driven from the winner in the issue cycle
//   mem_rdata           : memory read data, valid READ_LAT cycles after issue
//   busy                : a read is outstanding (issue cycle through READ_WAIT)
// -----------------------------------------------------------------------------
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
   localparam int unsigned LAT_W = $clog2(READ_LAT + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [LAT_W-1:0] LAT_INIT   = LAT_W'(READ_LAT);
   localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);

   arb_state_t        state_q;
   arb_owner_t        owner_q;
   logic [LAT_W-1:0]  lat_q;
   logic [CNT_W-1:0]  starve_q;
   logic [CNT_W-1:0]  starve_d;
   logic              cpu_rvalid_q;
   logic              ldr_rvalid_q;
   logic [DATA_W-1:0] cpu_rdata_q;
   logic [DATA_W-1:0] ldr_rdata_q;
   logic              cpu_win;
   logic              ldr_win;
   logic              issue_rd;

   // Winner select. Only IDLE arbitrates; reset forces the strobes quiet even
   // if a requester is already asserting.
   always_comb begin
      cpu_win = 1'b0;
      ldr_win = 1'b0;
      if (!rst && state_q == IDLE) begin
         if (cpu_req && ldr_req) begin
            if (starve_q == STARVE_LIM) ldr_win = 1'b1;
            else                        cpu_win = 1'b1;
         end else begin
            cpu_win = cpu_req;
            ldr_win = ldr_req;
         end
      end
   end

   // Saturating count of CPU grants taken while the loader was waiting.
   always_comb begin
      starve_d = starve_q;
      if (!ldr_req || ldr_win) begin
         starve_d = '0;
      end else if (cpu_win && starve_q != STARVE_LIM) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   assign cpu_gnt   = cpu_win;
   assign ldr_gnt   = ldr_win;
   assign mem_en    = cpu_win | ldr_win;
   assign mem_we    = cpu_win ? cpu_we    : (ldr_win ? ldr_we    : 1'b0);
   assign mem_addr  = cpu_win ? cpu_addr  : (ldr_win ? ldr_addr  : '0);
   assign mem_wdata = cpu_win ? cpu_wdata : (ldr_win ? ldr_wdata : '0);
   assign issue_rd  = mem_en & ~mem_we;

   // The issue cycle already counts as busy so the port reads as occupied for
   // the whole T..T+READ_LAT window.
   assign busy       = (state_q == READ_WAIT) | issue_rd;
   assign cpu_rvalid = cpu_rvalid_q;
   assign ldr_rvalid = ldr_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign ldr_rdata  = ldr_rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         owner_q      <= OWN_NONE;
         lat_q        <= '0;
         starve_q     <= '0;
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         ldr_rdata_q  <= '0;
      end else begin
         cpu_rvalid_q <= 1'b0;
         ldr_rvalid_q <= 1'b0;
         starve_q     <= starve_d;
         case (state_q)
            IDLE: begin
               if (issue_rd) begin
                  state_q <= READ_WAIT;
                  lat_q   <= LAT_INIT;
                  owner_q <= cpu_win ? OWN_CPU : OWN_LDR;
               end
            end
            READ_WAIT: begin
               lat_q <= lat_q - LAT_ONE;
               // Counter hits zero at this edge: mem_rdata is valid now.
               if (lat_q == LAT_ONE) begin
                  state_q <= IDLE;
                  owner_q <= OWN_NONE;
                  if (owner_q == OWN_CPU) begin
                     cpu_rdata_q  <= mem_rdata;
                     cpu_rvalid_q <= 1'b1;
                  end else if (owner_q == OWN_LDR) begin
                     ldr_rdata_q  <= mem_rdata;
                     ldr_rvalid_q <= 1'b1;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               owner_q <= OWN_NONE;
            end
         endcase
      end
   end

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Drives mem_arbiter (READ_LAT=2, STARVE_MAX=4) against a behavioural memory
// with a two-stage read pipeline. Read results are predicted from a bench-side
// reference image and queued at issue; a monitor pops and compares them on
// every rvalid pulse.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int READ_LAT   = 2;
   localparam int STARVE_MAX = 4;

   typedef struct {
      logic              is_ldr;
      logic [DATA_W-1:0] data;
   } sb_entry_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_req, cpu_we, ldr_req, ldr_we;
   logic [ADDR_W-1:0] cpu_addr, ldr_addr, mem_addr;
   logic [DATA_W-1:0] cpu_wdata, ldr_wdata, mem_wdata, mem_rdata;
   logic [DATA_W-1:0] cpu_rdata, ldr_rdata;
   logic              cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid;
   logic              mem_en, mem_we, busy;

   logic [DATA_W-1:0] mem_model [256];
   logic [DATA_W-1:0] ref_mem   [256];
   logic [DATA_W-1:0] rd_pipe   [READ_LAT];

   sb_entry_t sb [$];
   sb_entry_t mon_e;
   int        checks   = 0;
   int        failures = 0;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .READ_LAT  (READ_LAT),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt),
      .cpu_rvalid(cpu_rvalid),
      .cpu_rdata (cpu_rdata),
      .ldr_req   (ldr_req),
      .ldr_we    (ldr_we),
      .ldr_addr  (ldr_addr),
      .ldr_wdata (ldr_wdata),
      .ldr_gnt   (ldr_gnt),
      .ldr_rvalid(ldr_rvalid),
      .ldr_rdata (ldr_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   // Memory macro: write on mem_en&mem_we, read data appears READ_LAT cycles later.
   always @(posedge clk) begin
      if (mem_en && mem_we) mem_model[mem_addr] <= mem_wdata;
      rd_pipe[0] <= mem_model[mem_addr];
      for (int k = 1; k < READ_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[READ_LAT-1];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   // Read-completion monitor, sampled 3 time units after the falling edge.
   always @(negedge clk) begin
      #3;
      if (!rst && (cpu_rvalid || ldr_rvalid)) begin
         if (sb.size() == 0) begin
            check_eq("rvalid_unexpected", {30'd0, cpu_rvalid, ldr_rvalid}, 32'd0);
         end else begin
            mon_e = sb.pop_front();
            check_eq("rvalid_port", {31'd0, ldr_rvalid}, {31'd0, mon_e.is_ldr});
            check_eq("rvalid_data", mon_e.is_ldr ? ldr_rdata : cpu_rdata, mon_e.data);
            $display("rd  %s data=0x%02h", mon_e.is_ldr ? "ldr" : "cpu", mon_e.data);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      sb_entry_t e;
      int        ldr_n;
      logic      exp_ldr;

      for (int i = 0; i < 256; i++) begin
         mem_model[i] = DATA_W'(i) ^ 8'h5A;
         ref_mem[i]   = DATA_W'(i) ^ 8'h5A;
      end
      mem_model[8'h20] = 8'h3C;
      ref_mem[8'h20]   = 8'h3C;
      for (int k = 0; k < READ_LAT; k++) rd_pipe[k] = '0;

      rst = 1'b1;
      cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
      ldr_req = 0; ldr_we = 0; ldr_addr = '0; ldr_wdata = '0;
      repeat (2) next_cycle();
      settle();
      check_eq("rst_gnt",    {cpu_gnt, ldr_gnt}, 0);
      check_eq("rst_rvalid", {cpu_rvalid, ldr_rvalid}, 0);
      check_eq("rst_mem",    {mem_en, mem_we, busy}, 0);
      check_eq("rst_rdata",  {cpu_rdata, ldr_rdata}, 0);
      check_eq("rst_maddr",  {mem_addr, mem_wdata}, 0);
      $display("txn reset");

      // Single CPU write.
      next_cycle();
      rst = 1'b0;
      next_cycle();
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
      settle();
      check_eq("wr_gnt",   {cpu_gnt, ldr_gnt}, 2'b10);
      check_eq("wr_strobe", {mem_en, mem_we}, 2'b11);
      check_eq("wr_addr",  mem_addr, 8'h10);
      check_eq("wr_wdata", mem_wdata, 8'hA5);
      ref_mem[8'h10] = 8'hA5;
      $display("txn cpu wr addr=0x10 data=0xa5");
      next_cycle();
      cpu_req = 0;
      settle();
      check_eq("wr_idle", {cpu_gnt, ldr_gnt, mem_en, mem_we, busy}, 0);
      check_eq("wr_idle_bus", {mem_addr, mem_wdata}, 0);

      // CPU read with a loader read arriving during READ_WAIT.
      next_cycle();
      cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20;
      settle();
      check_eq("rd_T_gnt",  cpu_gnt, 1);
      check_eq("rd_T_busy", busy, 1);
      check_eq("rd_T_mem",  {mem_en, mem_we}, 2'b10);
      e.is_ldr = 1'b0; e.data = ref_mem[8'h20]; sb.push_back(e);
      $display("txn cpu rd addr=0x20");
      for (int c = 1; c <= READ_LAT; c++) begin
         next_cycle();
         cpu_req = 0;
         ldr_req = 1; ldr_we = 0; ldr_addr = 8'h05;
         settle();
         check_eq("rd_wait_busy", busy, 1);
         check_eq("rd_wait_mem",  mem_en, 0);
         check_eq("rd_wait_gnt",  {cpu_gnt, ldr_gnt}, 0);
      end
      next_cycle();
      settle();
      check_eq("rd_T3_rvalid", cpu_rvalid, 1);
      check_eq("rd_T3_rdata",  cpu_rdata, 8'h3C);
      check_eq("rd_T3_ldrgnt", ldr_gnt, 1);
      e.is_ldr = 1'b1; e.data = ref_mem[8'h05]; sb.push_back(e);
      $display("txn ldr rd addr=0x05");
      next_cycle();
      ldr_req = 0;
      repeat (READ_LAT) next_cycle();

      // Priority: both write together.
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h30; cpu_wdata = 8'h11;
      ldr_req = 1; ldr_we = 1; ldr_addr = 8'h31; ldr_wdata = 8'h22;
      settle();
      check_eq("pri_first", {cpu_gnt, ldr_gnt}, 2'b10);
      check_eq("pri_addr1", mem_addr, 8'h30);
      ref_mem[8'h30] = 8'h11;
      $display("txn cpu wr addr=0x30 (contested)");
      next_cycle();
      cpu_req = 0;
      settle();
      check_eq("pri_second", {cpu_gnt, ldr_gnt}, 2'b01);
      check_eq("pri_addr2", {mem_addr, mem_wdata}, {8'h31, 8'h22});
      ref_mem[8'h31] = 8'h22;
      $display("txn ldr wr addr=0x31");
      next_cycle();
      ldr_req = 0;

      // Starvation guard: CPU x4, loader, CPU x4, loader.
      next_cycle();
      ldr_n = 0;
      cpu_req = 1; cpu_we = 1;
      ldr_req = 1; ldr_we = 1;
      for (int i = 0; i < 10; i++) begin
         cpu_addr  = 8'h40 + 8'(i);  cpu_wdata = 8'(i);
         ldr_addr  = 8'h50 + 8'(ldr_n); ldr_wdata = 8'h80 + 8'(ldr_n);
         exp_ldr   = (i % (STARVE_MAX + 1)) == STARVE_MAX;
         settle();
         check_eq("starve_gnt", {cpu_gnt, ldr_gnt}, exp_ldr ? 2'b01 : 2'b10);
         check_eq("starve_addr", mem_addr, exp_ldr ? ldr_addr : cpu_addr);
         if (exp_ldr) begin
            ref_mem[ldr_addr] = ldr_wdata;
            ldr_n++;
         end else begin
            ref_mem[cpu_addr] = cpu_wdata;
         end
         $display("txn starve cycle %0d expect %s", i, exp_ldr ? "ldr" : "cpu");
         next_cycle();
      end
      cpu_req = 0; ldr_req = 0;

      // Back-to-back loader writes.
      next_cycle();
      for (int i = 0; i < 8; i++) begin
         ldr_req = 1; ldr_we = 1; ldr_addr = 8'(i); ldr_wdata = 8'hC0 + 8'(i);
         settle();
         check_eq("b2b_gnt", ldr_gnt, 1);
         ref_mem[i] = 8'hC0 + 8'(i);
         $display("txn ldr wr addr=0x%02h data=0x%02h", ldr_addr, ldr_wdata);
         next_cycle();
      end
      ldr_req = 0;
      next_cycle();
      for (int i = 0; i < 256; i++) check_eq($sformatf("mem[%0d]", i), mem_model[i], ref_mem[i]);

      // Reset in the middle of a loader read.
      ldr_req = 1; ldr_we = 0; ldr_addr = 8'h07;
      settle();
      check_eq("rstrd_gnt", ldr_gnt, 1);
      $display("txn ldr rd addr=0x07 (abandoned by reset)");
      next_cycle();
      ldr_req = 0;
      #1 rst = 1'b1;
      sb.delete();
      settle();
      check_eq("rstrd_busy",  busy, 0);
      check_eq("rstrd_rdata", ldr_rdata, 0);
      next_cycle();
      rst = 1'b0;
      cpu_req = 1; cpu_we = 1; cpu_addr = 8'h60; cpu_wdata = 8'h77;
      settle();
      check_eq("rstrd_cpu_gnt", cpu_gnt, 1);
      check_eq("rstrd_busy2",   busy, 0);
      $display("txn cpu wr addr=0x60 after reset");
      next_cycle();
      cpu_req = 0;
      for (int i = 0; i < READ_LAT + 2; i++) begin
         settle();
         check_eq("rstrd_no_rvalid", ldr_rvalid, 0);
         next_cycle();
      end
      check_eq("rstrd_rdata_end", ldr_rdata, 0);
      check_eq("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_mem_arbiter
